// File: rtl/fetch_queue_pkg.sv
// Shared frontend types for the fetch queue.
// Holds the queued entry layout and default depth.
package fetch_queue_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;
    localparam int IADDR_BITS        = 10;

    typedef logic [IADDR_BITS-1:0] Iaddr;
    typedef logic [31:0]           Inst;

    typedef struct packed {
        Iaddr pc;
        Inst  ir;
    } Fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, ir} entries.
// Registered storage, flush clears pointers and count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy tracking; flush empties the queue.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; written only when the caller pushes.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based prefetch into a FIFO.
// Handles redirects (jump), sleep and memory read latency of one.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = FETCH_QUEUE_DEPTH,
    parameter int IADDR_W = $bits(Iaddr)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       jump,
    input  logic [IADDR_W-1:0]         jump_vec,
    input  logic                       sleep,
    output logic                       imem_en,
    output logic [IADDR_W-1:0]         imem_addr,
    input  logic [31:0]                imem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IADDR_W-1:0]         out_pc,
    output logic [31:0]                out_ir,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [IADDR_W-1:0] fetch_pc;
    logic [IADDR_W-1:0] req_pc;
    logic               inflight;
    logic               credit;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     used;

    // Entries held plus the one read that will still land.
    assign used   = {1'b0, count} + (CNT_W+1)'(inflight);
    assign credit = used < (CNT_W+1)'(DEPTH);

    // A jump flushes the queue, so credit is implicitly available.
    assign imem_en   = reset & ~sleep & (jump | credit);
    assign imem_addr = jump ? jump_vec : fetch_pc;

    assign out_valid = reset & ~jump & (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = reset & inflight & ~jump;

    // Fetch PC advance, in-flight tracking and request PC capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                req_pc   <= imem_addr;
                fetch_pc <= imem_addr + 1'b1;
            end else if (jump) begin
                fetch_pc <= jump_vec;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IADDR_W + 32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (jump),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc, imem_data}),
        .rdata ({out_pc, out_ir}),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue.
// Memory word i holds 0x100 + i.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          jump;
    logic [AW-1:0] jump_vec;
    logic          sleep;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [31:0]   out_ir;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;
    logic prev_en = 1'b0;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .IADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .jump      (jump),
        .jump_vec  (jump_vec),
        .sleep     (sleep),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ir    (out_ir),
        .count     (count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory; garbage when not read.
    always @(posedge clk) begin
        imem_data <= imem_en ? (32'h100 + {22'd0, imem_addr}) : 32'hDEAD_BEEF;
        prev_en   <= imem_en;
    end

    // A returning read must never land on a full queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((prev_en && !jump && count == 3'(DEPTH)) || count > 3'(DEPTH)) begin
                errors++;
                $display("FAIL full_write: count=%0d inflight=%0b jump=%0b", count, prev_en, jump);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; jump = 1'b0; jump_vec = '0; sleep = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        #1;
        checks++;
        if ({imem_en, out_valid, count} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: en=%0b valid=%0b count=%0d expected 0 0 0", imem_en, out_valid, count);
        end
    endtask

    task automatic test_stream();
        tick(); reset = 1'b1; #1;
        checks++;
        if ({imem_en, imem_addr} !== {1'b1, 10'd0}) begin
            errors++;
            $display("FAIL first_read: en=%0b addr=%h expected 1 000", imem_en, imem_addr);
        end
        tick(); #1;
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 10'd1}) begin
            errors++;
            $display("FAIL stream_c1: valid=%0b addr=%h expected 0 001", out_valid, imem_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            checks++;
            if ({out_valid, out_pc, out_ir} !== {1'b1, 10'(i), 32'h100 + 32'(i)}) begin
                errors++;
                $display("FAIL stream_%0d: valid=%0b pc=%h ir=%h expected pc=%h", i, out_valid, out_pc, out_ir, i);
            end
        end
    endtask

    task automatic test_backpressure();
        tick(); out_ready = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            if (count == 3'd4) begin
                checks++;
                if (imem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_credit: en=%0b with count=4 expected 0", imem_en);
                end
            end
        end
        checks++;
        if ({count, imem_en} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL bp_full: count=%0d en=%0b expected 4 0", count, imem_en);
        end
        out_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_pc, out_ir} !== {1'b1, 10'(10 + i), 32'h100 + 32'(10 + i)}) begin
                errors++;
                $display("FAIL bp_drain_%0d: valid=%0b pc=%h expected %h", i, out_valid, out_pc, 10 + i);
            end
            tick(); #1;
        end
    endtask

    task automatic test_jump_full();
        out_ready = 1'b0;
        repeat (10) tick();
        #1;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL jf_fill: count=%0d expected 4", count);
        end
        tick(); jump = 1'b1; jump_vec = 10'h3F0; out_ready = 1'b1; #1;
        checks++;
        if ({imem_en, imem_addr, out_valid} !== {1'b1, 10'h3F0, 1'b0}) begin
            errors++;
            $display("FAIL jf_jump: en=%0b addr=%h valid=%0b expected 1 3f0 0", imem_en, imem_addr, out_valid);
        end
        tick(); jump = 1'b0; #1;
        checks++;
        if ({count, out_valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL jf_flush: count=%0d valid=%0b expected 0 0", count, out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            checks++;
            if ({out_valid, out_pc, out_ir} !== {1'b1, 10'(10'h3F0 + i), 32'h100 + 32'(10'(10'h3F0 + i))}) begin
                errors++;
                $display("FAIL jf_seq_%0d: valid=%0b pc=%h ir=%h", i, out_valid, out_pc, out_ir);
            end
        end
    endtask

    task automatic test_jump_inflight();
        tick(); jump = 1'b1; jump_vec = 10'h155; #1;
        checks++;
        if ({imem_en, imem_addr} !== {1'b1, 10'h155}) begin
            errors++;
            $display("FAIL ji_jump: en=%0b addr=%h expected 1 155", imem_en, imem_addr);
        end
        tick(); jump = 1'b0; #1;
        checks++;
        if ({count, out_valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL ji_discard: count=%0d valid=%0b expected 0 0", count, out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++;
            if ({out_valid, out_pc, out_ir} !== {1'b1, 10'(10'h155 + i), 32'h100 + 32'(10'h155 + i)}) begin
                errors++;
                $display("FAIL ji_seq_%0d: valid=%0b pc=%h ir=%h", i, out_valid, out_pc, out_ir);
            end
        end
    endtask

    task automatic test_sleep();
        tick(); sleep = 1'b1; out_ready = 1'b0; #1;
        checks++;
        if (imem_en !== 1'b0) begin
            errors++;
            $display("FAIL sl_block: en=%0b expected 0", imem_en);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++;
            if ({count, imem_en} !== {3'd2, 1'b0}) begin
                errors++;
                $display("FAIL sl_queued_%0d: count=%0d en=%0b expected 2 0", i, count, imem_en);
            end
        end
        tick(); jump = 1'b1; jump_vec = 10'h020; #1;
        checks++;
        if ({imem_en, imem_addr, out_valid} !== {1'b0, 10'h020, 1'b0}) begin
            errors++;
            $display("FAIL sl_jump: en=%0b addr=%h valid=%0b expected 0 020 0", imem_en, imem_addr, out_valid);
        end
        tick(); jump = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({count, imem_en, out_valid} !== {3'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL sl_idle_%0d: count=%0d en=%0b valid=%0b", i, count, imem_en, out_valid);
            end
            tick(); #1;
        end
        sleep = 1'b0; out_ready = 1'b1; #1;
        checks++;
        if ({imem_en, imem_addr} !== {1'b1, 10'h020}) begin
            errors++;
            $display("FAIL sl_resume: en=%0b addr=%h expected 1 020", imem_en, imem_addr);
        end
        tick(); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sl_lat: valid=%0b expected 0", out_valid);
        end
        tick(); #1;
        checks++;
        if ({out_valid, out_pc, out_ir} !== {1'b1, 10'h020, 32'h120}) begin
            errors++;
            $display("FAIL sl_first: valid=%0b pc=%h ir=%h expected 020", out_valid, out_pc, out_ir);
        end
    endtask

    task automatic test_reset_inflight();
        tick(); reset = 1'b0; #1;
        checks++;
        if ({imem_en, out_valid} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ri_hold: en=%0b valid=%0b expected 0 0", imem_en, out_valid);
        end
        tick(); reset = 1'b1; #1;
        checks++;
        if ({count, imem_en, imem_addr} !== {3'd0, 1'b1, 10'd0}) begin
            errors++;
            $display("FAIL ri_release: count=%0d en=%0b addr=%h expected 0 1 000", count, imem_en, imem_addr);
        end
        tick(); #1;
        checks++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL ri_discard: valid=%0b count=%0d expected 0 0", out_valid, count);
        end
        tick(); #1;
        checks++;
        if ({out_valid, out_pc, out_ir} !== {1'b1, 10'd0, 32'h100}) begin
            errors++;
            $display("FAIL ri_first: valid=%0b pc=%h ir=%h expected 000", out_valid, out_pc, out_ir);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_pc;
        int accepted;
        exp_pc = 10'd1;
        accepted = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            jump      = (i % 30 == 29);
            jump_vec  = 10'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            sleep     = ($urandom_range(0, 3) == 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if ({out_pc, out_ir} !== {exp_pc, 32'h100 + {22'd0, exp_pc}}) begin
                    errors++;
                    $display("FAIL rnd_%0d: pc=%h ir=%h expected pc=%h", i, out_pc, out_ir, exp_pc);
                end
                exp_pc = exp_pc + 1'b1;
                accepted++;
            end
            if (jump) exp_pc = jump_vec;
        end
        tick(); jump = 1'b0; sleep = 1'b0; #1;
        checks++;
        if (accepted < 100) begin
            errors++;
            $display("FAIL rnd_progress: accepted=%0d expected at least 100", accepted);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_full();
        test_jump_inflight();
        test_sleep();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001: Parameter DEPTH, default 4, queue entries; SHALL be a power of two and at least 2.
- REQ-002: Parameter IADDR_W, default $bits(Iaddr), instruction word-address width.
- REQ-003: clk  in  1  single clock; all state SHALL update on the rising edge.
- REQ-004: reset  in  1  synchronous, active-low reset.
- REQ-005: jump  in  1  redirect request, sampled every cycle.
- REQ-006: jump_vec  in  IADDR_W  redirect target word address.
- REQ-007: sleep  in  1  suppresses issuing new memory reads.
- REQ-008: imem_en  out  1  instruction memory read enable.
- REQ-009: imem_addr  out  IADDR_W  instruction memory read address.
- REQ-010: imem_data  in  32  read data, valid exactly one cycle after imem_en.
- REQ-011: out_valid  out  1  head entry is available to the consumer.
- REQ-012: out_ready  in  1  consumer accepts the head entry.
- REQ-013: out_pc  out  IADDR_W  PC of the head entry.
- REQ-014: out_ir  out  32  instruction word of the head entry.
- REQ-015: count  out  $clog2(DEPTH+1)  number of occupied entries.

Function
- REQ-016: Fetch PC register: reads SHALL go to consecutive word addresses, incrementing by 1 modulo 2**IADDR_W (all-ones wraps to 0).
- REQ-017: A read SHALL be issued (imem_en=1) when sleep=0 and count + inflight < DEPTH; inflight is 1 if a read was issued in the previous cycle and not cancelled.
- REQ-018: A returning read SHALL be written to the tail as {pc, imem_data} in the cycle the data is valid; it SHALL be readable at the head no earlier than the following cycle.
- REQ-019: Pop SHALL occur when out_valid & out_ready; push and pop in the same cycle SHALL leave count unchanged.
- REQ-020: out_valid SHALL equal (count != 0) & ~jump; out_pc/out_ir SHALL hold the head entry whenever out_valid=1.
- REQ-021: With DEPTH>=4, sleep=0 and out_ready held 1, throughput SHALL reach one instruction per cycle.
- REQ-022: Jump cycle: the queue SHALL be cleared (count=0 next cycle); a read completing in that cycle SHALL be discarded; any pop in that cycle SHALL be ignored.
- REQ-023: Jump cycle: imem_addr SHALL equal jump_vec, and imem_en SHALL equal ~sleep (the credit check passes because the queue is being flushed); the fetch PC SHALL become jump_vec+1 if a read was issued, otherwise jump_vec.
- REQ-024: Redirect latency: a jump in cycle t with sleep=0 SHALL produce out_valid=1 with out_pc=jump_vec in cycle t+2.
- REQ-025: sleep=1 SHALL block new reads only; an in-flight read SHALL still complete and be queued, and the queue SHALL keep draining normally.
- REQ-026: Jump during sleep SHALL flush the queue and redirect the fetch PC; fetching SHALL resume from jump_vec when sleep falls.
- REQ-027: A full queue SHALL never be written: the credit rule of REQ-017 SHALL guarantee this, and the bench SHALL assert it.

Reset
- REQ-028: While reset=0 at a clock edge: count=0, inflight=0, fetch PC=0, and the FIFO pointers SHALL be 0.
- REQ-029: During reset, imem_en SHALL be 0, out_valid SHALL be 0, and out_pc/out_ir SHALL be don't-care.
- REQ-030: A read in flight when reset asserts SHALL be discarded.
- REQ-031: The first read after reset deasserts SHALL go to address 0 in the first cycle with reset=1 and sleep=0.

Structure
- REQ-032: The Frontend package SHALL hold the struct Fetch_entry {Iaddr pc; Pu_inst::Inst ir;} and the constant FETCH_QUEUE_DEPTH=4.
- REQ-033: Storage SHALL be a single sub-module fetch_fifo: synchronous FIFO, registered storage, with push, pop, flush, count, and head data.
- REQ-034: Credit, fetch-PC and flush logic SHALL remain in fetch_queue.

Verification
- REQ-035: Reset release, memory word i = i+0x100, sleep=0, out_ready=1 -> out_pc 0,1,2,... on consecutive cycles from cycle 2, out_ir=0x100+pc.
- REQ-036: out_ready=0 for 20 cycles -> count saturates at 4, imem_en=0 while count+inflight=4, no entry lost or duplicated after out_ready=1.
- REQ-037: jump=1, jump_vec=0x3F0 while full -> count=0 next cycle; first out_pc=0x3F0 two cycles after the jump; stale PCs never appear.
- REQ-038: Fetch PC at all-ones with IADDR_W=10 -> next out_pc values 0x3FF then 0x000.
- REQ-039: sleep=1 with one read in flight -> that entry is queued, no further imem_en; jump to 0x20 during sleep, then sleep=0 -> first out_pc=0x20.
- REQ-040: Random jumps every 30 cycles plus random out_ready, checked by an assertion -> out_ir equals memory[out_pc] for every accepted entry.
